// File: rtl/sync_fifo_stream_rd.sv
// Downstream read adapter for the synchronous pointer FIFO.
// Issues FIFO reads, absorbs the one-cycle registered read latency in a
// two-entry skid buffer, and presents the words as a valid/ready stream
// framed into fixed-length packets with first/last markers.
module sync_fifo_stream_rd #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  pkt_done
);

    // Beat counter width; PKT_LEN = 2 still needs one bit.
    localparam int                BEAT_W    = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    // Buffer occupancy (0..2) and the read-issued-last-cycle marker.
    logic [1:0]            cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    // buf0 is always the head; buf1 only holds a word while buf0 is occupied.
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                  pkt_done_q, pkt_done_d;

    logic                  pop;
    logic [2:0]            occ_next;   // cnt + inflight - pop, also the next cnt
    logic [1:0]            tail_slot;  // slot the arriving word lands in

    assign m_valid  = (cnt_q != 2'd0);
    assign m_data   = buf0_q;
    assign m_first  = (beat_cnt_q == '0);
    assign m_last   = (beat_cnt_q == LAST_BEAT);
    assign pkt_done = pkt_done_q;

    // Occupancy bookkeeping and the read-enable decision (m_ready/fifo_empty
    // reach fifo_rd_en combinationally so a pop frees a slot the same cycle).
    always_comb begin
        pop        = m_valid && m_ready;
        occ_next   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        tail_slot  = cnt_q - {1'b0, pop};
        fifo_rd_en = rst_n && !fifo_empty && (occ_next < 3'd2);
    end

    // Next-state logic for buffer, framing counter and done pulse.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        cnt_d      = occ_next[1:0];
        inflight_d = fifo_rd_en;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        beat_cnt_d = beat_cnt_q;
        pkt_done_d = pop && m_last;

        // Pop shifts the second entry forward to the head.
        if (pop) begin
            buf0_d = buf1_q;
        end

        // The word requested last cycle is on fifo_data now; append it.
        if (inflight_q) begin
            if (tail_slot == 2'd0) begin
                buf0_d = fifo_data;
            end else begin
                buf1_d = fifo_data;
            end
        end

        // Framing advances only on an accepted beat, so stalls never skip a boundary.
        if (pop) begin
            if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
        end
    end

    // State registers with synchronous active-low reset; a reset discards
    // buffered and in-flight words.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
            // NOTE: data registers are reset too so m_data reads 0 out of reset.
            buf0_q     <= '0;
            buf1_q     <= '0;
            beat_cnt_q <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    // An arriving word must always find a free slot.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(inflight_q && (cnt_q == 2'd2)));

endmodule

// File: doc/sync_fifo_stream_rd.md
Name: sync_fifo_stream_rd

Overview:
Downstream read adapter for the team's synchronous pointer FIFO (registered read, one-cycle latency).
- Drives the FIFO's read enable and absorbs its read latency in a 2-entry output buffer.
- Presents a valid/ready stream to the consumer, framed into fixed-length packets with first/last markers.
- Sustains one beat per cycle when the FIFO is non-empty and the consumer is ready.

Parameters:
DATA_WIDTH, 8, width of FIFO word and stream data
PKT_LEN, 16, beats per packet; legal range 2..65535

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset; synchronous, active-low
fifo_rd_en  output  1  read enable to FIFO
fifo_data  input  DATA_WIDTH  FIFO data_out; valid in the cycle after fifo_rd_en was high with fifo_empty low
fifo_empty  input  1  FIFO empty flag
m_valid  output  1  stream beat valid
m_ready  input  1  consumer accepts beat
m_data  output  DATA_WIDTH  stream data
m_first  output  1  beat is first of packet
m_last  output  1  beat is last of packet
pkt_done  output  1  one-cycle pulse when a last beat is accepted

Behaviour:
- Reset: clk and rst_n only; synchronous, active-low.
- Registered values while rst_n low and on the first cycle after release:
  - buffer count = 0, inflight = 0, beat_cnt = 0, pkt_done = 0
  - hence m_valid = 0, m_first = 1, m_last = 0, m_data = 0
- fifo_rd_en = rst_n && !fifo_empty && (cnt + inflight - pop) < 2.
  - pop = m_valid && m_ready.
  - Combinational path from m_ready and fifo_empty to fifo_rd_en is intended.
- inflight register: set to fifo_rd_en each cycle.
  - When inflight = 1, fifo_data is written into the buffer tail at the end of that cycle.
- Buffer: 2-entry FIFO of registers; head drives m_data.
  - cnt_next = cnt + (inflight ? 1 : 0) - (pop ? 1 : 0).
  - Push and pop in the same cycle are both honoured.
  - The rd_en rule guarantees the buffer never overflows.
  - Push when cnt = 2 is a design error; assert in simulation.
- m_valid = (cnt != 0). No combinational path from fifo_data to m_data.
- Latency: rd_en high in cycle T → fifo_data valid T+1 → m_valid high T+2 (buffer previously empty).
- Stream rules:
  - m_data, m_first and m_last hold stable while m_valid && !m_ready.
  - m_valid never drops without a pop.
- Throughput: FIFO continuously non-empty and m_ready held high gives one pop per cycle after the initial 2-cycle fill.
- Framing:
  - beat_cnt (width clog2(PKT_LEN)) increments on pop; wraps to 0 after the pop where beat_cnt = PKT_LEN-1.
  - m_first = (beat_cnt == 0); m_last = (beat_cnt == PKT_LEN-1).
  - Both are decoded from beat_cnt and qualified only by m_valid at the consumer.
- pkt_done: registered, high for one cycle after the cycle in which pop && m_last.
- Boundary conditions:
  - FIFO empty: fifo_rd_en = 0. Buffered beats still drain.
  - FIFO goes empty in the cycle after a read: the in-flight word is still captured.
  - m_ready low with buffer full: fifo_rd_en = 0 even if FIFO non-empty.
  - Packet boundary across a stall: beat_cnt is unchanged until pop.
- Reset mid-operation:
  - Buffer contents, inflight and beat_cnt are discarded.
  - A word whose read was issued in the cycle before reset asserted is dropped.
  - The system resets the FIFO in the same cycle; no recovery of that word is required.

Test Plan:
1. Reset release with FIFO holding 3 words A,B,C and m_ready = 1 → rd_en high cycles 0..2; m_valid high cycles 2..4 with m_data A,B,C; m_first on A; rd_en low once fifo_empty.
2. Continuous stream of 40 words, PKT_LEN = 16, m_ready = 1 → one beat per cycle after 2-cycle fill; m_last on beats 15 and 31; m_first on beats 0, 16, 32; pkt_done pulses the cycle after beats 15 and 31.
3. m_ready low for 5 cycles mid-stream with FIFO non-empty → buffer fills to 2 and rd_en goes low; m_data and m_last stable throughout; on m_ready high, data order is preserved with no loss or duplication.
4. m_ready toggling 1,0,1,0 with FIFO supplying one word every 3 cycles → scoreboard matches exactly; cnt never exceeds 2; no push-on-full assertion fires.
5. rst_n low for 1 cycle while cnt = 2 and inflight = 1, FIFO reset alongside → next cycle m_valid = 0, beat_cnt = 0, m_first = 1; subsequent packet framing restarts at beat 0.
6. PKT_LEN = 2 with 4 words → m_first/m_last alternate; pkt_done pulses twice.
